mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
Shares one single-port unified memory between the IF stage (instruction fetch, read-only) and the MEM stage (data load/store) of the 5-stage RISC-V pipeline. It grants one requester at a time and drives a req/ready memory handshake. It returns read data with a one-cycle valid pulse and produces per-stage stall signals that freeze the pipeline registers. A watchdog aborts memory transactions that never complete.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, data width
TIMEOUT, 15, maximum cycles a granted transaction may wait for m_ready before it is aborted; must be >= 1

Ports:
clk  in  1  system clock, rising edge
rst  in  1  synchronous, active-low reset
if_req  in  1  IF-stage read request; held until if_valid is seen
if_addr  in  ADDR_W  fetch address
if_rdata  out  DATA_W  fetched instruction, registered
if_valid  out  1  one-cycle completion pulse for an IF request
if_stall  out  1  freeze IF/ID-side registers
mem_rd_req  in  1  MEM-stage load request
mem_wr_req  in  1  MEM-stage store request; never asserted together with mem_rd_req
mem_addr  in  ADDR_W  load/store address
mem_wdata  in  DATA_W  store data
mem_rdata  out  DATA_W  load data, registered
mem_valid  out  1  one-cycle completion pulse for a MEM request (load or store)
mem_stall  out  1  freeze pipeline while a MEM access is outstanding
m_req  out  1  memory request, registered
m_we  out  1  memory write enable, registered
m_addr  out  ADDR_W  memory address, registered
m_wdata  out  DATA_W  memory write data, registered
m_rdata  in  DATA_W  memory read data; valid when m_ready=1
m_ready  in  1  memory completion; sampled only while m_req=1
timeout_err  out  1  sticky abort flag

Behaviour:
- Clocking and reset: all state changes on the rising edge of clk. When rst=0 at an edge, the next state is: state IDLE, wait counter 0, m_req/m_we=0, m_addr/m_wdata=0, if_rdata/mem_rdata=0, if_valid/mem_valid=0, timeout_err=0.
- FSM states: IDLE, BUSY_IF, BUSY_MEM, RESP.
- IDLE:
  - If mem_rd_req or mem_wr_req is high, latch mem_addr, mem_wdata and m_we=mem_wr_req into the m_* registers, set m_req=1, and go to BUSY_MEM.
  - Otherwise, if if_req is high, latch if_addr, set m_we=0 and m_req=1, and go to BUSY_IF.
  - MEM has fixed priority over IF because it holds the older instruction. IF waits and is not starved, because at most one MEM access is pending per instruction.
- BUSY_x:
  - m_req, m_we, m_addr and m_wdata stay stable.
  - The wait counter increments each cycle that m_ready=0.
  - On m_ready=1: capture m_rdata into the owner's rdata register (loads/fetches only; stores leave mem_rdata unchanged), clear m_req, and go to RESP.
  - If the counter reaches TIMEOUT-1 with m_ready=0: clear m_req, load rdata=0 into the owner, set timeout_err=1, and go to RESP.
- RESP:
  - Exactly one cycle. The owner's valid output is 1; the other valid is 0.
  - No new grant is made in this cycle, even if requests are pending. This lets requesters drop req.
  - Next state is IDLE; the counter clears.
- Latency: with m_ready in the first BUSY cycle, the sequence is request seen in IDLE (cycle 0), m_req=1 (cycle 1), valid=1 (cycle 2), IDLE (cycle 3). Back-to-back throughput is 1 access per 3 cycles.
- Stall logic (combinational):
  - if_stall = if_req & ~if_valid
  - mem_stall = (mem_rd_req | mem_wr_req) & ~mem_valid
  - Both may be high at once. mem_stall also freezes IF via the existing pipeline stall chain.
- A requester that drops its req mid-transaction does not cancel it. The transaction completes and valid still pulses.
- timeout_err is sticky and cleared only by reset. The arbiter keeps operating after a timeout.
- Reset mid-transaction: the pending access is dropped. m_req=0 after the reset edge and no valid pulse is generated.
- m_ready while m_req=0 is ignored.

Test Plan:
- Reset: rst=0 for 2 cycles with if_req=1 and mem_rd_req=1 -> m_req, if_valid, mem_valid, timeout_err all 0; first m_req rises 1 cycle after rst=1, with addr=mem_addr.
- IF fetch: if_addr=0x0000_0040, m_ready=1 on the 2nd BUSY cycle with m_rdata=0x0050_0093 -> m_addr=0x40, m_we=0; if_valid pulses exactly once with if_rdata=0x0050_0093; if_stall is high from request until the valid cycle, then low.
- Conflict: if_req=1 and mem_wr_req=1 (addr 0x100, data 0xDEAD_BEEF) in the same cycle, m_ready=1 immediately -> the first transaction has m_we=1, m_addr=0x100, m_wdata=0xDEAD_BEEF, and mem_valid fires; the IF request is granted in the IDLE after RESP; if_stall stays high throughout.
- Timeout: TIMEOUT=4, MEM load at 0x200, m_ready held 0 -> m_req high for exactly 4 cycles; mem_valid=1 with mem_rdata=0; timeout_err=1 and remains 1 through a later successful IF fetch.
- Reset in BUSY_MEM: assert rst=0 on the 2nd BUSY cycle -> m_req=0 next cycle, no mem_valid pulse, state IDLE; re-issued request completes normally.
- Throughput: if_req held high across 3 fetches, m_ready=1 whenever m_req=1 -> if_valid pulses on cycles 2, 5 and 8; m_req is never high in a RESP cycle.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-port memory between the IF (fetch) and MEM (load/store) pipeline stages.
// MEM has fixed priority; a watchdog aborts transactions that never see m_ready.
module mem_port_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_valid,
    output logic              if_stall,

    input  logic              mem_rd_req,
    input  logic              mem_wr_req,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_wdata,
    output logic [DATA_W-1:0] mem_rdata,
    output logic              mem_valid,
    output logic              mem_stall,

    output logic              m_req,
    output logic              m_we,
    output logic [ADDR_W-1:0] m_addr,
    output logic [DATA_W-1:0] m_wdata,
    input  logic [DATA_W-1:0] m_rdata,
    input  logic              m_ready,

    output logic              timeout_err
);

    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    localparam logic [1:0] S_IDLE     = 2'd0;
    localparam logic [1:0] S_BUSY_IF  = 2'd1;
    localparam logic [1:0] S_BUSY_MEM = 2'd2;
    localparam logic [1:0] S_RESP     = 2'd3;

    logic [1:0]       state;
    logic [1:0]       state_next;
    logic [CNT_W-1:0] wait_cnt;

    logic mem_any_req;
    logic busy;
    logic grant_mem;
    logic grant_if;
    logic complete;
    logic expired;
    logic abort;

    assign mem_any_req = mem_rd_req | mem_wr_req;
    assign busy        = (state == S_BUSY_IF) || (state == S_BUSY_MEM);

    assign grant_mem = (state == S_IDLE) && mem_any_req;
    assign grant_if  = (state == S_IDLE) && !mem_any_req && if_req;

    // m_ready only counts while a transaction is actually outstanding.
    assign complete = busy && m_ready;
    assign expired  = (wait_cnt == CNT_W'(TIMEOUT - 1));
    assign abort    = busy && !m_ready && expired;

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: begin
                if (grant_mem) begin
                    state_next = S_BUSY_MEM;
                end else if (grant_if) begin
                    state_next = S_BUSY_IF;
                end
            end
            S_BUSY_IF, S_BUSY_MEM: begin
                if (complete || abort) begin
                    state_next = S_RESP;
                end
            end
            S_RESP: begin
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= S_IDLE;
            wait_cnt <= '0;
        end else begin
            state <= state_next;
            if (busy && !m_ready && !expired) begin
                wait_cnt <= wait_cnt + CNT_W'(1);
            end else if (!busy) begin
                wait_cnt <= '0;
            end
        end
    end

    // Request registers hold steady from grant until completion or abort.
    always_ff @(posedge clk) begin
        if (!rst) begin
            m_req   <= 1'b0;
            m_we    <= 1'b0;
            m_addr  <= '0;
            m_wdata <= '0;
        end else begin
            if (grant_mem) begin
                m_req   <= 1'b1;
                m_we    <= mem_wr_req;
                m_addr  <= mem_addr;
                m_wdata <= mem_wdata;
            end else if (grant_if) begin
                m_req  <= 1'b1;
                m_we   <= 1'b0;
                m_addr <= if_addr;
            end else if (complete || abort) begin
                m_req <= 1'b0;
            end
        end
    end

    // Response side: valid pulses are registered so they line up with the RESP cycle.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if_rdata    <= '0;
            mem_rdata   <= '0;
            if_valid    <= 1'b0;
            mem_valid   <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            if_valid  <= 1'b0;
            mem_valid <= 1'b0;
            if (complete) begin
                if (state == S_BUSY_MEM) begin
                    mem_valid <= 1'b1;
                    if (!m_we) begin
                        mem_rdata <= m_rdata;
                    end
                end else begin
                    if_valid <= 1'b1;
                    if_rdata <= m_rdata;
                end
            end else if (abort) begin
                timeout_err <= 1'b1;
                if (state == S_BUSY_MEM) begin
                    mem_valid <= 1'b1;
                    mem_rdata <= '0;
                end else begin
                    if_valid <= 1'b1;
                    if_rdata <= '0;
                end
            end
        end
    end

    assign if_stall  = if_req & ~if_valid;
    assign mem_stall = mem_any_req & ~mem_valid;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter, built with TIMEOUT=4 so the watchdog is reachable.
// Inputs change and outputs are sampled 1 time unit after each rising edge.
module tb_mem_port_arbiter;

    logic        clk;
    logic        rst;
    logic        if_req;
    logic [31:0] if_addr;
    logic [31:0] if_rdata;
    logic        if_valid;
    logic        if_stall;
    logic        mem_rd_req;
    logic        mem_wr_req;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_valid;
    logic        mem_stall;
    logic        m_req;
    logic        m_we;
    logic [31:0] m_addr;
    logic [31:0] m_wdata;
    logic [31:0] m_rdata;
    logic        m_ready;
    logic        timeout_err;

    int check_cnt = 0;
    int pass_cnt  = 0;

    mem_port_arbiter #(
        .ADDR_W (32),
        .DATA_W (32),
        .TIMEOUT(4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .if_req     (if_req),
        .if_addr    (if_addr),
        .if_rdata   (if_rdata),
        .if_valid   (if_valid),
        .if_stall   (if_stall),
        .mem_rd_req (mem_rd_req),
        .mem_wr_req (mem_wr_req),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .mem_valid  (mem_valid),
        .mem_stall  (mem_stall),
        .m_req      (m_req),
        .m_we       (m_we),
        .m_addr     (m_addr),
        .m_wdata    (m_wdata),
        .m_rdata    (m_rdata),
        .m_ready    (m_ready),
        .timeout_err(timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst        = 1'b0;
        if_req     = 1'b1;
        if_addr    = 32'h0000_0010;
        mem_rd_req = 1'b1;
        mem_wr_req = 1'b0;
        mem_addr   = 32'h0000_0300;
        mem_wdata  = 32'h0;
        m_rdata    = 32'h0;
        m_ready    = 1'b0;
        tick();
        tick();
        check_cnt++; if (m_req !== 1'b0) $display("[TB] FAIL reset_m_req: got %0h want 0", m_req); else pass_cnt++;
        check_cnt++; if (if_valid !== 1'b0 || mem_valid !== 1'b0) $display("[TB] FAIL reset_valids: got if=%0h mem=%0h want 0/0", if_valid, mem_valid); else pass_cnt++;
        check_cnt++; if (timeout_err !== 1'b0) $display("[TB] FAIL reset_timeout_err: got %0h want 0", timeout_err); else pass_cnt++;
        check_cnt++; if (m_addr !== 32'h0) $display("[TB] FAIL reset_m_addr: got %h want 0", m_addr); else pass_cnt++;
        rst = 1'b1;
        tick();
        check_cnt++; if (m_req !== 1'b1 || m_addr !== 32'h0000_0300 || m_we !== 1'b0) $display("[TB] FAIL reset_first_grant: got req=%0h addr=%h we=%0h want 1/00000300/0", m_req, m_addr, m_we); else pass_cnt++;
        m_ready = 1'b1;
        m_rdata = 32'h0000_1234;
        tick();
        check_cnt++; if (mem_valid !== 1'b1 || if_valid !== 1'b0 || mem_rdata !== 32'h0000_1234) $display("[TB] FAIL reset_first_load: got mv=%0h iv=%0h rdata=%h want 1/0/00001234", mem_valid, if_valid, mem_rdata); else pass_cnt++;
        check_cnt++; if (m_req !== 1'b0) $display("[TB] FAIL reset_resp_m_req: got %0h want 0", m_req); else pass_cnt++;
        if_req     = 1'b0;
        mem_rd_req = 1'b0;
        m_ready    = 1'b0;
        tick();
        check_cnt++; if (m_req !== 1'b0 || mem_valid !== 1'b0) $display("[TB] FAIL reset_back_idle: got req=%0h mv=%0h want 0/0", m_req, mem_valid); else pass_cnt++;
    endtask

    task automatic test_if_fetch();
        int pulses = 0;
        if_req  = 1'b1;
        if_addr = 32'h0000_0040;
        #1;
        check_cnt++; if (if_stall !== 1'b1) $display("[TB] FAIL fetch_stall_req: got %0h want 1", if_stall); else pass_cnt++;
        tick();
        check_cnt++; if (m_req !== 1'b1 || m_addr !== 32'h0000_0040 || m_we !== 1'b0) $display("[TB] FAIL fetch_grant: got req=%0h addr=%h we=%0h want 1/00000040/0", m_req, m_addr, m_we); else pass_cnt++;
        check_cnt++; if (if_stall !== 1'b1 || if_valid !== 1'b0) $display("[TB] FAIL fetch_busy1: got stall=%0h valid=%0h want 1/0", if_stall, if_valid); else pass_cnt++;
        tick();
        check_cnt++; if (m_req !== 1'b1 || if_stall !== 1'b1 || if_valid !== 1'b0) $display("[TB] FAIL fetch_busy2: got req=%0h stall=%0h valid=%0h want 1/1/0", m_req, if_stall, if_valid); else pass_cnt++;
        m_ready = 1'b1;
        m_rdata = 32'h0050_0093;
        tick();
        if (if_valid === 1'b1) pulses++;
        check_cnt++; if (if_valid !== 1'b1 || if_rdata !== 32'h0050_0093) $display("[TB] FAIL fetch_resp: got valid=%0h rdata=%h want 1/00500093", if_valid, if_rdata); else pass_cnt++;
        check_cnt++; if (if_stall !== 1'b0 || m_req !== 1'b0) $display("[TB] FAIL fetch_resp_stall: got stall=%0h req=%0h want 0/0", if_stall, m_req); else pass_cnt++;
        if_req  = 1'b0;
        m_ready = 1'b0;
        tick();
        if (if_valid === 1'b1) pulses++;
        tick();
        if (if_valid === 1'b1) pulses++;
        check_cnt++; if (pulses !== 1) $display("[TB] FAIL fetch_pulse_count: got %0d want 1", pulses); else pass_cnt++;
    endtask

    task automatic test_conflict();
        if_req     = 1'b1;
        if_addr    = 32'h0000_0044;
        mem_wr_req = 1'b1;
        mem_addr   = 32'h0000_0100;
        mem_wdata  = 32'hDEAD_BEEF;
        m_ready    = 1'b1;
        m_rdata    = 32'h5555_5555;
        tick();
        check_cnt++; if (m_req !== 1'b1 || m_we !== 1'b1 || m_addr !== 32'h0000_0100 || m_wdata !== 32'hDEAD_BEEF) $display("[TB] FAIL conflict_store_grant: got req=%0h we=%0h addr=%h wdata=%h want 1/1/00000100/deadbeef", m_req, m_we, m_addr, m_wdata); else pass_cnt++;
        check_cnt++; if (if_stall !== 1'b1 || mem_stall !== 1'b1) $display("[TB] FAIL conflict_stalls_busy: got if=%0h mem=%0h want 1/1", if_stall, mem_stall); else pass_cnt++;
        tick();
        check_cnt++; if (mem_valid !== 1'b1 || if_valid !== 1'b0) $display("[TB] FAIL conflict_store_resp: got mv=%0h iv=%0h want 1/0", mem_valid, if_valid); else pass_cnt++;
        check_cnt++; if (mem_rdata !== 32'h0000_1234) $display("[TB] FAIL conflict_store_keeps_rdata: got %h want 00001234", mem_rdata); else pass_cnt++;
        check_cnt++; if (if_stall !== 1'b1 || mem_stall !== 1'b0) $display("[TB] FAIL conflict_stalls_resp: got if=%0h mem=%0h want 1/0", if_stall, mem_stall); else pass_cnt++;
        mem_wr_req = 1'b0;
        tick();
        check_cnt++; if (m_req !== 1'b0 || if_stall !== 1'b1) $display("[TB] FAIL conflict_idle_gap: got req=%0h stall=%0h want 0/1", m_req, if_stall); else pass_cnt++;
        m_rdata = 32'h0000_ABCD;
        tick();
        check_cnt++; if (m_req !== 1'b1 || m_we !== 1'b0 || m_addr !== 32'h0000_0044) $display("[TB] FAIL conflict_if_grant: got req=%0h we=%0h addr=%h want 1/0/00000044", m_req, m_we, m_addr); else pass_cnt++;
        tick();
        check_cnt++; if (if_valid !== 1'b1 || if_rdata !== 32'h0000_ABCD || mem_valid !== 1'b0) $display("[TB] FAIL conflict_if_resp: got iv=%0h rdata=%h mv=%0h want 1/0000abcd/0", if_valid, if_rdata, mem_valid); else pass_cnt++;
        if_req  = 1'b0;
        m_ready = 1'b0;
        tick();
    endtask

    task automatic test_timeout();
        int  req_cycles = 0;
        bit  seen       = 1'b0;
        mem_rd_req = 1'b1;
        mem_addr   = 32'h0000_0200;
        m_ready    = 1'b0;
        for (int i = 0; i < 12 && !seen; i++) begin
            tick();
            if (m_req === 1'b1) req_cycles++;
            if (mem_valid === 1'b1) begin
                seen = 1'b1;
                check_cnt++; if (mem_rdata !== 32'h0 || timeout_err !== 1'b1 || m_req !== 1'b0) $display("[TB] FAIL timeout_resp: got rdata=%h err=%0h req=%0h want 0/1/0", mem_rdata, timeout_err, m_req); else pass_cnt++;
            end
        end
        check_cnt++; if (!seen) $display("[TB] FAIL timeout_no_valid: got no mem_valid within 12 cycles want a pulse"); else pass_cnt++;
        check_cnt++; if (req_cycles !== 4) $display("[TB] FAIL timeout_req_cycles: got %0d want 4", req_cycles); else pass_cnt++;
        mem_rd_req = 1'b0;
        tick();
        if_req  = 1'b1;
        if_addr = 32'h0000_0080;
        m_ready = 1'b1;
        m_rdata = 32'h0011_2233;
        tick();
        tick();
        check_cnt++; if (if_valid !== 1'b1 || if_rdata !== 32'h0011_2233 || timeout_err !== 1'b1) $display("[TB] FAIL timeout_sticky: got iv=%0h rdata=%h err=%0h want 1/00112233/1", if_valid, if_rdata, timeout_err); else pass_cnt++;
        if_req  = 1'b0;
        m_ready = 1'b0;
        tick();
    endtask

    task automatic test_reset_busy();
        mem_rd_req = 1'b1;
        mem_addr   = 32'h0000_0300;
        m_ready    = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        tick();
        check_cnt++; if (m_req !== 1'b0 || mem_valid !== 1'b0 || timeout_err !== 1'b0) $display("[TB] FAIL busy_reset: got req=%0h mv=%0h err=%0h want 0/0/0", m_req, mem_valid, timeout_err); else pass_cnt++;
        rst = 1'b1;
        tick();
        check_cnt++; if (m_req !== 1'b1 || m_addr !== 32'h0000_0300 || mem_valid !== 1'b0) $display("[TB] FAIL busy_reissue: got req=%0h addr=%h mv=%0h want 1/00000300/0", m_req, m_addr, mem_valid); else pass_cnt++;
        m_ready = 1'b1;
        m_rdata = 32'h0000_55AA;
        tick();
        check_cnt++; if (mem_valid !== 1'b1 || mem_rdata !== 32'h0000_55AA) $display("[TB] FAIL busy_reissue_resp: got mv=%0h rdata=%h want 1/000055aa", mem_valid, mem_rdata); else pass_cnt++;
        mem_rd_req = 1'b0;
        m_ready    = 1'b0;
        tick();
    endtask

    task automatic test_back_to_back();
        logic [9:0] valid_mask   = '0;
        logic [9:0] req_mask     = '0;
        logic [9:0] exp_valid    = 10'b01_0010_0100;
        logic [9:0] exp_req      = 10'b00_1001_0010;
        int         overlap      = 0;
        if_req  = 1'b1;
        if_addr = 32'h0000_0100;
        m_ready = 1'b1;
        m_rdata = 32'h0000_0013;
        for (int c = 1; c <= 9; c++) begin
            tick();
            valid_mask[c] = if_valid;
            req_mask[c]   = m_req;
            if (if_valid === 1'b1 && m_req === 1'b1) overlap++;
            if (c == 8) if_req = 1'b0;
        end
        check_cnt++; if (valid_mask !== exp_valid) $display("[TB] FAIL b2b_valid_cycles: got %b want %b", valid_mask, exp_valid); else pass_cnt++;
        check_cnt++; if (req_mask !== exp_req) $display("[TB] FAIL b2b_req_cycles: got %b want %b", req_mask, exp_req); else pass_cnt++;
        check_cnt++; if (overlap !== 0) $display("[TB] FAIL b2b_req_in_resp: got %0d overlaps want 0", overlap); else pass_cnt++;
        m_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_if_fetch();
        test_conflict();
        test_timeout();
        test_reset_busy();
        test_back_to_back();
        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
